noise_acq_gate: RTL and testbench

Parametrised noise-acquisition window controller for the NMR receive path. Counts rising edges of the ADC sample clock inside the `clk_sys` domain and asserts `en` for a programmed number of samples after a programmed pre-delay, repeating for a programmed number of segments. Adds start/abort/busy/done handshaking for the sequencer and multi-segment noise averaging. Sits between the pulse-sequence controller and the ADC capture/FIFO enable.

---
 rtl/noise_acq_gate_if.sv | 27 ++
 rtl/noise_acq_gate.sv | 146 ++++++++++++++
 tb/tb_noise_acq_gate.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/noise_acq_gate_if.sv
// Sequencer-side bus of the noise acquisition gate: shadow-register loads, run control,
// acquisition gate and run status.
interface noise_acq_gate_if #(
    parameter int unsigned CNT_W = 16,
    parameter int unsigned REP_W = 8
);
    logic             load;
    logic [CNT_W-1:0] acqnum;
    logic [CNT_W-1:0] dlynum;
    logic [REP_W-1:0] repnum;
    logic             start;
    logic             abort;
    logic             en;
    logic             busy;
    logic             done;
    logic [REP_W-1:0] seg_idx;

    modport master (
        output load, acqnum, dlynum, repnum, start, abort,
        input  en, busy, done, seg_idx
    );

    modport slave (
        input  load, acqnum, dlynum, repnum, start, abort,
        output en, busy, done, seg_idx
    );
endinterface

// File: rtl/noise_acq_gate.sv
// Noise-acquisition window controller: gates the ADC capture for acqnum samples after dlynum
// samples, repnum times. Define NOISE_ACQ_SYNC_EN to pass clkin through a 2-FF synchronizer.
module noise_acq_gate #(
    parameter int unsigned CNT_W = 16,
    parameter int unsigned REP_W = 8
) (
    input  logic              clk_sys,
    input  logic              rst_n,
    input  logic              clkin,
    noise_acq_gate_if.slave   bus
);
    typedef enum logic [1:0] {StIdle, StDelay, StAcq, StFinish} state_e;

    localparam logic [CNT_W-1:0] CntOne = 1;
    localparam logic [REP_W-1:0] RepOne = 1;

    state_e           state_q;
    logic [CNT_W-1:0] acq_sh_q, dly_sh_q, run_acq_q, run_dly_q, cnt_q;
    logic [REP_W-1:0] rep_sh_q, run_rep_q, seg_q;
    logic             en_q, busy_q, done_q;
    logic             clkin_c, clkin_prev_q, tick_q;
    logic [CNT_W-1:0] cnt_inc;
    logic [REP_W-1:0] seg_inc;
    logic             acq_end;

`ifdef NOISE_ACQ_SYNC_EN
    logic sync1_q, sync2_q;

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= clkin;
            sync2_q <= sync1_q;
        end
    end

    assign clkin_c = sync2_q;
`else
    assign clkin_c = clkin;
`endif

    // Registered rising-edge strobe of the conditioned sample clock.
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            clkin_prev_q <= 1'b0;
            tick_q       <= 1'b0;
        end else begin
            clkin_prev_q <= clkin_c;
            tick_q       <= clkin_c & ~clkin_prev_q;
        end
    end

    assign cnt_inc = cnt_q + CntOne;
    assign seg_inc = seg_q + RepOne;
    // A zero-length window still occupies one ACQ cycle so the segment is counted.
    assign acq_end = (run_acq_q == '0) || (tick_q && (cnt_inc == run_acq_q));

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            acq_sh_q  <= '0;
            dly_sh_q  <= '0;
            rep_sh_q  <= '0;
            run_acq_q <= '0;
            run_dly_q <= '0;
            run_rep_q <= '0;
            cnt_q     <= '0;
            seg_q     <= '0;
            en_q      <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (!busy_q && bus.load) begin
                acq_sh_q <= bus.acqnum;
                dly_sh_q <= bus.dlynum;
                rep_sh_q <= bus.repnum;
            end
            if ((state_q != StIdle) && bus.abort) begin
                state_q <= StIdle;
                en_q    <= 1'b0;
                busy_q  <= 1'b0;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        if (bus.start) begin
                            // Run copies let a coincident load target the next run only.
                            run_acq_q <= acq_sh_q;
                            run_dly_q <= dly_sh_q;
                            run_rep_q <= (rep_sh_q == '0) ? RepOne : rep_sh_q;
                            cnt_q     <= '0;
                            seg_q     <= '0;
                            busy_q    <= 1'b1;
                            if (dly_sh_q == '0) begin
                                state_q <= StAcq;
                                en_q    <= (acq_sh_q != '0);
                            end else begin
                                state_q <= StDelay;
                            end
                        end
                    end
                    StDelay: begin
                        if (tick_q) begin
                            if (cnt_inc == run_dly_q) begin
                                cnt_q   <= '0;
                                state_q <= StAcq;
                                en_q    <= (run_acq_q != '0);
                            end else begin
                                cnt_q <= cnt_inc;
                            end
                        end
                    end
                    StAcq: begin
                        // Re-arming here yields the one-cycle gap between back-to-back segments.
                        en_q <= (run_acq_q != '0);
                        if (acq_end) begin
                            en_q  <= 1'b0;
                            cnt_q <= '0;
                            if (seg_inc != run_rep_q) begin
                                seg_q   <= seg_inc;
                                state_q <= (run_dly_q == '0) ? StAcq : StDelay;
                            end else begin
                                state_q <= StFinish;
                                done_q  <= 1'b1;
                            end
                        end else if (tick_q) begin
                            cnt_q <= cnt_inc;
                        end
                    end
                    StFinish: begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    assign bus.en      = en_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.seg_idx = seg_q;
endmodule

// File: tb/tb_noise_acq_gate.sv
// Directed self-checking bench for noise_acq_gate; clkin pulses are 3 cycles high, 3 low.
module tb_noise_acq_gate;
    localparam int unsigned CNT_W = 16;
    localparam int unsigned REP_W = 8;
`ifdef NOISE_ACQ_SYNC_EN
    localparam int TickStep = 2;
`else
    localparam int TickStep = 0;
`endif

    logic clk_sys = 1'b0;
    logic rst_n   = 1'b0;
    logic clkin   = 1'b0;

    noise_acq_gate_if #(.CNT_W(CNT_W), .REP_W(REP_W)) bus ();

    noise_acq_gate #(.CNT_W(CNT_W), .REP_W(REP_W)) dut (
        .clk_sys (clk_sys),
        .rst_n   (rst_n),
        .clkin   (clkin),
        .bus     (bus)
    );

    always #5 clk_sys = ~clk_sys;

    int checks = 0;
    int failures = 0;
    int en_cyc, busy_cyc, done_cnt, rises, gaps1, low_run, win_ticks, seg_sum;
    logic prev_en;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic clr();
        en_cyc = 0; busy_cyc = 0; done_cnt = 0; rises = 0; gaps1 = 0;
        low_run = 0; win_ticks = 0; seg_sum = 0;
        prev_en = bus.en;
    endtask

    task automatic sample();
        if (bus.en) en_cyc++;
        if (bus.busy) busy_cyc++;
        if (bus.done) done_cnt++;
        if (bus.en && !prev_en) begin
            rises++;
            if (low_run == 1) gaps1++;
            low_run = 0;
        end else if (!bus.en && bus.busy) begin
            low_run++;
        end
        prev_en = bus.en;
    endtask

    task automatic step();
        @(posedge clk_sys);
        #1;
        sample();
    endtask

    task automatic pulse(input int n);
        for (int i = 0; i < n; i++) begin
            clkin = 1'b1;
            for (int s = 0; s < 6; s++) begin
                if (s == 3) clkin = 1'b0;
                step();
                // Gate state during the cycle the strobe is presented to the FSM.
                if (s == TickStep && bus.en) begin
                    win_ticks++;
                    seg_sum += int'(bus.seg_idx);
                end
            end
        end
    endtask

    task automatic do_load(input int a, input int d, input int r);
        bus.acqnum = CNT_W'(a);
        bus.dlynum = CNT_W'(d);
        bus.repnum = REP_W'(r);
        bus.load = 1'b1;
        step();
        bus.load = 1'b0;
    endtask

    task automatic do_start();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.load = 1'b0; bus.start = 1'b0; bus.abort = 1'b0;
        bus.acqnum = '0; bus.dlynum = '0; bus.repnum = '0;
        prev_en = 1'b0;
        clr();
        step();
        step();
        chk("rst_en", 32'(bus.en), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_done", 32'(bus.done), 0);
        chk("rst_seg", 32'(bus.seg_idx), 0);
        rst_n = 1'b1;
        step();

        // Single segment with pre-delay.
        do_load(10, 5, 1);
        clr();
        do_start();
        chk("t2_busy_rise", 32'(bus.busy), 1);
        chk("t2_en_delay", 32'(bus.en), 0);
        pulse(17);
        chk("t2_win_ticks", win_ticks, 10);
        chk("t2_en_cycles", en_cyc, 60);
        chk("t2_done_cnt", done_cnt, 1);
        chk("t2_busy_cycles", busy_cyc, 87 + TickStep);
        chk("t2_busy_end", 32'(bus.busy), 0);

        // Three back-to-back segments, no pre-delay.
        do_load(4, 0, 3);
        clr();
        do_start();
        chk("t3_en_immediate", 32'(bus.en), 1);
        pulse(14);
        chk("t3_win_ticks", win_ticks, 12);
        chk("t3_rises", rises, 3);
        chk("t3_gaps_1cyc", gaps1, 2);
        chk("t3_seg_sum", seg_sum, 12);
        chk("t3_seg_final", 32'(bus.seg_idx), 2);
        chk("t3_done_cnt", done_cnt, 1);
        chk("t3_busy_end", 32'(bus.busy), 0);

        // Zero-length window, repnum 0 treated as one segment.
        do_load(0, 0, 0);
        clr();
        do_start();
        chk("t4_busy", 32'(bus.busy), 1);
        chk("t4_done_early", 32'(bus.done), 0);
        step();
        chk("t4_done", 32'(bus.done), 1);
        step();
        chk("t4_busy_end", 32'(bus.busy), 0);
        chk("t4_done_end", 32'(bus.done), 0);
        chk("t4_no_en", rises, 0);

        // Abort at tick 7; mid-run start/load must be ignored.
        do_load(20, 0, 1);
        clr();
        do_start();
        pulse(2);
        bus.start = 1'b1;
        bus.load = 1'b1;
        bus.acqnum = 16'd2;
        step();
        bus.start = 1'b0;
        bus.load = 1'b0;
        pulse(4);
        clkin = 1'b1;
        repeat (TickStep + 1) step();
        chk("t5_en_at_tick7", 32'(bus.en), 1);
        bus.abort = 1'b1;
        step();
        bus.abort = 1'b0;
        clkin = 1'b0;
        chk("t5_abort_en", 32'(bus.en), 0);
        chk("t5_abort_busy", 32'(bus.busy), 0);
        step();
        step();
        pulse(3);
        chk("t5_no_done", done_cnt, 0);
        chk("t5_idle_after", 32'(bus.busy), 0);
        clr();
        do_start();
        pulse(24);
        chk("t5_rerun_ticks", win_ticks, 20);
        chk("t5_rerun_done", done_cnt, 1);

        // Start with coincident load: this run keeps 8, next run gets 3.
        do_load(8, 0, 1);
        clr();
        bus.acqnum = 16'd3;
        bus.load = 1'b1;
        bus.start = 1'b1;
        step();
        bus.load = 1'b0;
        bus.start = 1'b0;
        pulse(10);
        chk("t6_old_ticks", win_ticks, 8);
        chk("t6_old_done", done_cnt, 1);
        clr();
        do_start();
        pulse(5);
        chk("t6_new_ticks", win_ticks, 3);
        chk("t6_new_done", done_cnt, 1);

        // Reset at tick 40 of a 100-sample window.
        do_load(100, 0, 1);
        clr();
        do_start();
        pulse(39);
        clkin = 1'b1;
        repeat (TickStep + 1) step();
        chk("t1_en_before_rst", 32'(bus.en), 1);
        rst_n = 1'b0;
        #1;
        chk("t1_rst_en", 32'(bus.en), 0);
        chk("t1_rst_busy", 32'(bus.busy), 0);
        chk("t1_rst_done", 32'(bus.done), 0);
        chk("t1_rst_seg", 32'(bus.seg_idx), 0);
        @(posedge clk_sys);
        #1;
        rst_n = 1'b1;
        clkin = 1'b0;
        clr();
        step();
        step();
        pulse(4);
        chk("t1_quiet_en", en_cyc, 0);
        chk("t1_quiet_busy", busy_cyc, 0);
        chk("t1_quiet_done", done_cnt, 0);
        // Shadows were cleared: an unloaded start is a zero-length single segment.
        clr();
        do_start();
        chk("t1_post_busy", 32'(bus.busy), 1);
        step();
        chk("t1_post_done", 32'(bus.done), 1);
        step();
        chk("t1_post_idle", 32'(bus.busy), 0);
        chk("t1_post_no_en", en_cyc, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
